// File: rtl/picorv32_mem_pkg.sv
// picorv32_mem_pkg: shared types and defaults for the two-master memory arbiter.
package picorv32_mem_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0 = 2'b01;
    localparam logic [1:0] GRANT_M1 = 2'b10;
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-input round-robin picker; on a tie the master that did not go last wins.
module mem_arb_rr2
    import picorv32_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);
    assign win = (&req) ? ~last : req[1];
endmodule

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: round-robin share of one PicoRV32 memory slave between two masters.
// Define ARB_TIMEOUT_EN to add a watchdog that force-completes unacknowledged transfers.
module picorv32_mem_arbiter
    import picorv32_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(DEF_TIMEOUT_RDATA)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                m0_valid_i,
    input  logic                m0_instr_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_valid_i,
    input  logic                m1_instr_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_valid_o,
    output logic                s_instr_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic [1:0]          grant_o,
    output logic                err_o
);
    arb_state_t state, state_d;
    logic owner, owner_d, last, last_d, pick, busy, own_valid, fire, done;
    logic [DATA_W-1:0] rdata_sel;

    mem_arb_rr2 u_rr (.req({m1_valid_i, m0_valid_i}), .last(last), .win(pick));

    assign busy      = (state == BUSY);
    assign own_valid = owner ? m1_valid_i : m0_valid_i;
    assign done      = s_ready_i || fire;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !busy) cnt <= '0;
        else if (!s_ready_i) cnt <= cnt + 16'd1;
    end
    assign fire = busy && own_valid && !s_ready_i && (cnt == TO_LAST);
`else
    logic [15:0] unused_cfg;
    assign unused_cfg = 16'(TIMEOUT_CYCLES);
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_d;
            owner <= owner_d;
            last  <= last_d;
        end
    end

    // A master that drops valid mid-transfer is abandoned without a ready pulse.
    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last;
        if (!busy) begin
            if (m0_valid_i || m1_valid_i) begin
                state_d = BUSY;
                owner_d = pick;
            end
        end else if (done) begin
            state_d = IDLE;
            last_d  = owner;
        end else if (!own_valid) begin
            state_d = IDLE;
        end
    end

    assign s_valid_o = busy && own_valid;
    assign s_instr_o = busy && (owner ? m1_instr_i : m0_instr_i);
    assign s_addr_o  = busy ? (owner ? m1_addr_i : m0_addr_i) : '0;
    assign s_wdata_o = busy ? (owner ? m1_wdata_i : m0_wdata_i) : '0;
    assign s_wstrb_o = busy ? (owner ? m1_wstrb_i : m0_wstrb_i) : '0;
    assign grant_o   = busy ? (owner ? GRANT_M1 : GRANT_M0) : GRANT_NONE;
    assign err_o     = fire;

    assign rdata_sel  = fire ? TIMEOUT_RDATA : s_rdata_i;
    assign m0_ready_o = busy && !owner && done;
    assign m1_ready_o = busy && owner && done;
    assign m0_rdata_o = (busy && !owner) ? rdata_sel : '0;
    assign m1_rdata_o = (busy && owner) ? rdata_sel : '0;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: scoreboard bench for the two-master arbiter.
// Build with ARB_TIMEOUT_EN to exercise the watchdog instead of the silent-slave case.
module tb_picorv32_mem_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    logic clk_i = 1'b0;
    logic rst_n_i;
    logic m0_valid_i, m0_instr_i, m0_ready_o, m1_valid_i, m1_instr_i, m1_ready_o;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o, m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0] m0_wstrb_i, m1_wstrb_i, s_wstrb_o;
    logic s_valid_o, s_instr_o, s_ready_i, err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [1:0] grant_o;

    typedef struct {
        logic        m;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int vec = 0;
    int miss = 0;

    always #5 clk_i = ~clk_i;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_valid_i(m0_valid_i), .m0_instr_i(m0_instr_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i), .m1_instr_i(m1_instr_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
        .s_valid_o(s_valid_o), .s_instr_o(s_instr_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    task automatic idle_inputs();
        m0_valid_i = 0; m0_instr_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_wstrb_i = 0;
        m1_valid_i = 0; m1_instr_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_wstrb_i = 0;
        s_ready_i = 0; s_rdata_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_i = 0;
        m0_valid_i = 1; m0_addr_i = 32'h100; s_rdata_i = 32'h5555_5555;
        repeat (2) @(negedge clk_i);
        #1;
        vec++;
        if (grant_o !== 2'b00 || s_valid_o !== 1'b0) begin
            miss++; $display("FAIL reset_grant: grant=%b s_valid=%b, want 00/0", grant_o, s_valid_o);
        end
        vec++;
        if ({m0_ready_o, m1_ready_o, err_o} !== 3'b000) begin
            miss++; $display("FAIL reset_ready: m0/m1/err=%b, want 000", {m0_ready_o, m1_ready_o, err_o});
        end
        vec++;
        if (m0_rdata_o !== 0 || m1_rdata_o !== 0 || s_addr_o !== 0) begin
            miss++; $display("FAIL reset_data: m0_rdata=%h m1_rdata=%h s_addr=%h, want 0", m0_rdata_o, m1_rdata_o, s_addr_o);
        end
        @(negedge clk_i);
        rst_n_i = 1;
        idle_inputs();
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        m0_valid_i = 1; m0_addr_i = 32'h100; m0_instr_i = 1; m0_wstrb_i = 0;
        m1_addr_i = 32'h999; m1_wstrb_i = 4'hF;
        sb.push_back('{1'b0, 32'h1234_5678});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            #1;
            vec++;
            if (grant_o !== 2'b01 || s_valid_o !== 1'b1 || s_addr_o !== 32'h100 || s_instr_o !== 1'b1 || s_wstrb_o !== 4'h0) begin
                miss++;
                $display("FAIL read_busy c%0d: grant=%b s_valid=%b addr=%h instr=%b wstrb=%h, want 01/1/100/1/0",
                         c, grant_o, s_valid_o, s_addr_o, s_instr_o, s_wstrb_o);
            end
            vec++;
            if (m0_ready_o !== 1'b0 || m1_ready_o !== 1'b0) begin
                miss++; $display("FAIL read_early_ready c%0d: m0=%b m1=%b, want 0/0", c, m0_ready_o, m1_ready_o);
            end
        end
        @(negedge clk_i);
        s_ready_i = 1; s_rdata_i = 32'h1234_5678;
        #1;
        vec++;
        if (m0_ready_o !== 1'b1 || m1_ready_o !== 1'b0) begin
            miss++; $display("FAIL read_ready: m0=%b m1=%b, want 1/0", m0_ready_o, m1_ready_o);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vec++;
            if (m0_rdata_o !== e.d || m1_rdata_o !== 32'h0) begin
                miss++; $display("FAIL read_rdata: m0=%h m1=%h, want %h/0", m0_rdata_o, m1_rdata_o, e.d);
            end
        end
        @(negedge clk_i);
        s_ready_i = 0; m0_valid_i = 0;
        #1;
        vec++;
        if (s_valid_o !== 1'b0 || grant_o !== 2'b00 || m0_ready_o !== 1'b0) begin
            miss++; $display("FAIL read_after: s_valid=%b grant=%b m0_ready=%b, want 0/00/0", s_valid_o, grant_o, m0_ready_o);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] g [6];
        logic [31:0] rd [3];
        int k;
        g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        rd = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
        k = 0;
        @(negedge clk_i);
        rst_n_i = 0;
        @(negedge clk_i);
        rst_n_i = 1;
        m0_valid_i = 1; m0_addr_i = 32'h10; m1_valid_i = 1; m1_addr_i = 32'h20;
        s_ready_i = 1; s_rdata_i = rd[0];
        sb.push_back('{1'b0, rd[0]});
        sb.push_back('{1'b1, rd[1]});
        sb.push_back('{1'b0, rd[2]});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (c == 5) begin m0_valid_i = 0; m1_valid_i = 0; end
            s_rdata_i = rd[(k < 3) ? k : 2];
            #1;
            vec++;
            if (grant_o !== g[c] || s_valid_o !== (g[c] != 2'b00)) begin
                miss++; $display("FAIL rr_grant c%0d: grant=%b s_valid=%b, want %b/%b", c, grant_o, s_valid_o, g[c], g[c] != 2'b00);
            end
            if ((m0_ready_o || m1_ready_o) && sb.size() != 0) begin
                e = sb.pop_front();
                vec++;
                if (m1_ready_o !== e.m || (m0_ready_o && m1_ready_o) || (e.m ? m1_rdata_o : m0_rdata_o) !== e.d) begin
                    miss++; $display("FAIL rr_done c%0d: m0=%b m1=%b rdata=%h/%h, want master %0d rdata %h",
                                     c, m0_ready_o, m1_ready_o, m0_rdata_o, m1_rdata_o, e.m, e.d);
                end
                k++;
            end
        end
        vec++;
        if (k != 3) begin
            miss++; $display("FAIL rr_count: completions=%0d, want 3", k);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        m1_valid_i = 1; m1_addr_i = 32'h400;
        @(negedge clk_i);
        #1;
        vec++;
        if (grant_o !== 2'b10 || s_valid_o !== 1'b1) begin
            miss++; $display("FAIL rst_mid_busy: grant=%b s_valid=%b, want 10/1", grant_o, s_valid_o);
        end
        @(negedge clk_i);
        rst_n_i = 0;
        @(negedge clk_i);
        #1;
        vec++;
        if (s_valid_o !== 1'b0 || grant_o !== 2'b00 || m1_ready_o !== 1'b0 || m0_ready_o !== 1'b0) begin
            miss++; $display("FAIL rst_mid_drop: s_valid=%b grant=%b m0=%b m1=%b, want 0/00/0/0", s_valid_o, grant_o, m0_ready_o, m1_ready_o);
        end
        rst_n_i = 1;
        m0_valid_i = 1; m0_addr_i = 32'h440;
        sb.push_back('{1'b0, 32'h0000_0077});
        @(negedge clk_i);
        #1;
        vec++;
        if (grant_o !== 2'b01) begin
            miss++; $display("FAIL rst_mid_tie: grant=%b, want 01", grant_o);
        end
        s_ready_i = 1; s_rdata_i = 32'h0000_0077;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vec++;
            if (m0_ready_o !== 1'b1 || m1_ready_o !== 1'b0 || m0_rdata_o !== e.d) begin
                miss++; $display("FAIL rst_mid_done: m0=%b m1=%b rdata=%h, want 1/0/%h", m0_ready_o, m1_ready_o, m0_rdata_o, e.d);
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_write_m1();
        @(negedge clk_i);
        m1_valid_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'hCAFE_F00D; m1_wstrb_i = 4'b0011; m1_instr_i = 0;
        m0_addr_i = 32'h111; m0_wdata_i = 32'h2222_2222; m0_wstrb_i = 4'hF; m0_instr_i = 1;
        sb.push_back('{1'b1, 32'h0BAD_0BAD});
        @(negedge clk_i);
        #1;
        vec++;
        if (grant_o !== 2'b10 || s_valid_o !== 1'b1 || s_addr_o !== 32'h200 || s_wdata_o !== 32'hCAFE_F00D ||
            s_wstrb_o !== 4'b0011 || s_instr_o !== 1'b0) begin
            miss++;
            $display("FAIL write_mux: grant=%b s_valid=%b addr=%h wdata=%h wstrb=%b instr=%b, want 10/1/200/cafef00d/0011/0",
                     grant_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o, s_instr_o);
        end
        s_ready_i = 1; s_rdata_i = 32'h0BAD_0BAD;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vec++;
            if (m1_ready_o !== 1'b1 || m0_ready_o !== 1'b0 || m1_rdata_o !== e.d || m0_rdata_o !== 32'h0) begin
                miss++; $display("FAIL write_done: m0=%b m1=%b rdata=%h/%h, want 0/1/0/%h", m0_ready_o, m1_ready_o, m0_rdata_o, m1_rdata_o, e.d);
            end
        end
        @(negedge clk_i);
        s_ready_i = 0; m1_valid_i = 0;
        #1;
        vec++;
        if (s_valid_o !== 1'b0 || grant_o !== 2'b00 || m1_ready_o !== 1'b0) begin
            miss++; $display("FAIL write_after: s_valid=%b grant=%b m1=%b, want 0/00/0", s_valid_o, grant_o, m1_ready_o);
        end
        idle_inputs();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk_i);
            m0_valid_i = 1; m0_addr_i = 32'h600; s_rdata_i = 32'h1212_1212;
            sb.push_back('{1'b0, (r == 1) ? 32'h55AA_55AA : 32'hDEAD_BEEF});
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk_i);
                if (c == 8 && r == 1) begin s_ready_i = 1; s_rdata_i = 32'h55AA_55AA; end
                #1;
                if (c < 8) begin
                    vec++;
                    if (m0_ready_o !== 1'b0 || err_o !== 1'b0 || s_valid_o !== 1'b1) begin
                        miss++; $display("FAIL to_wait r%0d c%0d: ready=%b err=%b s_valid=%b, want 0/0/1", r, c, m0_ready_o, err_o, s_valid_o);
                    end
                end else if (sb.size() != 0) begin
                    e = sb.pop_front();
                    vec++;
                    if (m0_ready_o !== 1'b1 || err_o !== (r == 0) || s_valid_o !== 1'b1 || m0_rdata_o !== e.d) begin
                        miss++; $display("FAIL to_fire r%0d: ready=%b err=%b s_valid=%b rdata=%h, want 1/%0d/1/%h",
                                         r, m0_ready_o, err_o, s_valid_o, m0_rdata_o, r == 0, e.d);
                    end
                end
            end
            @(negedge clk_i);
            s_ready_i = 0; m0_valid_i = 0;
            #1;
            vec++;
            if (s_valid_o !== 1'b0 || grant_o !== 2'b00 || err_o !== 1'b0) begin
                miss++; $display("FAIL to_after r%0d: s_valid=%b grant=%b err=%b, want 0/00/0", r, s_valid_o, grant_o, err_o);
            end
        end
        idle_inputs();
    endtask
`else
    task automatic test_silent_slave();
        int bad;
        bad = 0;
        @(negedge clk_i);
        m0_valid_i = 1; m0_addr_i = 32'h500;
        sb.push_back('{1'b0, 32'h600D_F00D});
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_i);
            #1;
            if (s_valid_o !== 1'b1 || err_o !== 1'b0 || m0_ready_o !== 1'b0) bad++;
        end
        vec++;
        if (bad != 0) begin
            miss++; $display("FAIL silent_hold: %0d bad cycles (s_valid=%b err=%b ready=%b), want 0", bad, s_valid_o, err_o, m0_ready_o);
        end
        @(negedge clk_i);
        s_ready_i = 1; s_rdata_i = 32'h600D_F00D;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vec++;
            if (m0_ready_o !== 1'b1 || err_o !== 1'b0 || m0_rdata_o !== e.d) begin
                miss++; $display("FAIL silent_done: ready=%b err=%b rdata=%h, want 1/0/%h", m0_ready_o, err_o, m0_rdata_o, e.d);
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_reset_mid();
        test_write_m1();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_silent_slave();
`endif
        vec++;
        if (sb.size() != 0) begin
            miss++; $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
